// File: rtl/rotator_pkg.sv
// Shared constants, frame layout and tag type for the rotator scheduler.
package rotator_pkg;

    localparam int BUS_SIZE_DEF  = 32;
    localparam int WORD_SIZE_DEF = 4;
    localparam int WORD_NUM_DEF  = BUS_SIZE_DEF / WORD_SIZE_DEF;
    localparam int PAY_SIZE_DEF  = BUS_SIZE_DEF - 2 * WORD_SIZE_DEF;

    localparam logic [WORD_SIZE_DEF-1:0] HEADER_WORD = '1;

    typedef struct packed {
        logic valid;
        logic id;
    } tag_t;

    // The amount word doubles as the frame tail, so it is passed through untouched.
    function automatic logic [BUS_SIZE_DEF-1:0] build_frame(
        input logic [PAY_SIZE_DEF-1:0]  payload,
        input logic [WORD_SIZE_DEF-1:0] amount
    );
        return {HEADER_WORD, payload, amount};
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; the last-grant pointer resets to 1 so requester 0 wins first.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant = 2'b00;
        if (reset) begin
            if (req[0] && req[1]) begin
                grant = last_q ? 2'b01 : 2'b10;
            end else begin
                grant = req;
            end
        end
    end

    always_comb begin
        last_d = last_q;
        if (grant[1]) begin
            last_d = 1'b1;
        end else if (grant[0]) begin
            last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/rotator_scheduler.sv
// Shares one word rotator between two requesters: issues frames, tracks ownership
// through the rotator latency, returns tagged results and counts errors per owner.
module rotator_scheduler
    import rotator_pkg::*;
#(
    parameter int BUS_SIZE    = BUS_SIZE_DEF,
    parameter int WORD_SIZE   = WORD_SIZE_DEF,
    parameter int WORD_NUM    = BUS_SIZE / WORD_SIZE,
    parameter int PAY_SIZE    = BUS_SIZE - 2 * WORD_SIZE,
    parameter int ROT_LATENCY = 1,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [PAY_SIZE-1:0]  req0_payload,
    input  logic [WORD_SIZE-1:0] req0_amount,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [PAY_SIZE-1:0]  req1_payload,
    input  logic [WORD_SIZE-1:0] req1_amount,
    output logic [BUS_SIZE-1:0]  rot_data_in,
    input  logic [BUS_SIZE-1:0]  rot_data_out,
    input  logic [WORD_NUM-1:0]  rot_control_out,
    input  logic                 rot_error_out,
    output logic                 rsp_valid,
    output logic                 rsp_id,
    output logic [BUS_SIZE-1:0]  rsp_data,
    output logic [WORD_NUM-1:0]  rsp_control,
    output logic                 rsp_error,
    output logic [ERR_CNT_W-1:0] err_cnt0,
    output logic [ERR_CNT_W-1:0] err_cnt1
);

    logic [1:0] grant;
    logic       transfer;

    logic [BUS_SIZE-1:0]  rot_data_in_q, rot_data_in_d;
    tag_t [ROT_LATENCY:0] tag_q, tag_d;
    tag_t                 resp_tag;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_id_q, rsp_id_d;
    logic [BUS_SIZE-1:0]  rsp_data_q, rsp_data_d;
    logic [WORD_NUM-1:0]  rsp_control_q, rsp_control_d;
    logic                 rsp_error_q, rsp_error_d;
    logic [ERR_CNT_W-1:0] err_cnt0_q, err_cnt0_d;
    logic [ERR_CNT_W-1:0] err_cnt1_q, err_cnt1_d;

    rr_arbiter2 u_arbiter (
        .clk   (clk),
        .reset (reset),
        .req   ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign transfer   = |grant;

    // Idle cycles drive an all-zero frame so the rotator never sees a valid header.
    always_comb begin
        rot_data_in_d = '0;
        if (transfer) begin
            rot_data_in_d = grant[1] ? build_frame(req1_payload, req1_amount)
                                     : build_frame(req0_payload, req0_amount);
        end
    end

    always_comb begin
        tag_d          = '0;
        tag_d[0].valid = transfer;
        tag_d[0].id    = grant[1];
        for (int i = 1; i <= ROT_LATENCY; i++) begin
            tag_d[i] = tag_q[i-1];
        end
    end

    assign resp_tag = tag_q[ROT_LATENCY];

    always_comb begin
        rsp_valid_d   = resp_tag.valid;
        rsp_id_d      = rsp_id_q;
        rsp_data_d    = rsp_data_q;
        rsp_control_d = rsp_control_q;
        rsp_error_d   = rsp_error_q;
        err_cnt0_d    = err_cnt0_q;
        err_cnt1_d    = err_cnt1_q;
        if (resp_tag.valid) begin
            rsp_id_d      = resp_tag.id;
            rsp_data_d    = rot_data_out;
            rsp_control_d = rot_control_out;
            rsp_error_d   = rot_error_out;
            if (rot_error_out) begin
                if (!resp_tag.id && (err_cnt0_q != '1)) begin
                    err_cnt0_d = err_cnt0_q + 1'b1;
                end
                if (resp_tag.id && (err_cnt1_q != '1)) begin
                    err_cnt1_d = err_cnt1_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rot_data_in_q <= '0;
            tag_q         <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_id_q      <= 1'b0;
            rsp_data_q    <= '0;
            rsp_control_q <= '0;
            rsp_error_q   <= 1'b0;
            err_cnt0_q    <= '0;
            err_cnt1_q    <= '0;
        end else begin
            rot_data_in_q <= rot_data_in_d;
            tag_q         <= tag_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_id_q      <= rsp_id_d;
            rsp_data_q    <= rsp_data_d;
            rsp_control_q <= rsp_control_d;
            rsp_error_q   <= rsp_error_d;
            err_cnt0_q    <= err_cnt0_d;
            err_cnt1_q    <= err_cnt1_d;
        end
    end

    assign rot_data_in = rot_data_in_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_data    = rsp_data_q;
    assign rsp_control = rsp_control_q;
    assign rsp_error   = rsp_error_q;
    assign err_cnt0    = err_cnt0_q;
    assign err_cnt1    = err_cnt1_q;

endmodule

// File: tb/tb_rotator_scheduler.sv
// Randomized bench for rotator_scheduler: a simple stand-in rotator plus a
// transaction-level model of arbitration, issue, response return and error counting.
module tb_rotator_scheduler;

    localparam int BUS  = 32;
    localparam int WS   = 4;
    localparam int WN   = 8;
    localparam int PAY  = 24;
    localparam int LAT  = 1;
    localparam int CW   = 8;

    logic            clk;
    logic            reset;
    logic            req0_valid, req1_valid;
    logic            req0_ready, req1_ready;
    logic [PAY-1:0]  req0_payload, req1_payload;
    logic [WS-1:0]   req0_amount, req1_amount;
    logic [BUS-1:0]  rot_data_in;
    logic [BUS-1:0]  rot_data_out;
    logic [WN-1:0]   rot_control_out;
    logic            rot_error_out;
    logic            rsp_valid, rsp_id, rsp_error;
    logic [BUS-1:0]  rsp_data;
    logic [WN-1:0]   rsp_control;
    logic [CW-1:0]   err_cnt0, err_cnt1;

    int tests_run    = 0;
    int tests_failed = 0;

    rotator_scheduler #(
        .BUS_SIZE(BUS), .WORD_SIZE(WS), .ROT_LATENCY(LAT), .ERR_CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_payload(req0_payload), .req0_amount(req0_amount),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_payload(req1_payload), .req1_amount(req1_amount),
        .rot_data_in(rot_data_in), .rot_data_out(rot_data_out),
        .rot_control_out(rot_control_out), .rot_error_out(rot_error_out),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_control(rsp_control), .rsp_error(rsp_error),
        .err_cnt0(err_cnt0), .err_cnt1(err_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BUS-1:0] rot_scramble(input logic [BUS-1:0] x);
        return {x[BUS-5:0], x[BUS-1:BUS-4]} ^ 32'h5A5A_5A5A;
    endfunction

    function automatic logic [WN-1:0] rot_ctl(input logic [BUS-1:0] x);
        return x[7:0] ^ x[15:8];
    endfunction

    function automatic logic rot_err(input logic [BUS-1:0] x);
        return (x[BUS-1:BUS-4] == 4'hF) && (x[3:0] >= 4'd8);
    endfunction

    // Stand-in rotator with a single edge of latency.
    always @(posedge clk) begin
        rot_data_out    <= rot_scramble(rot_data_in);
        rot_control_out <= rot_ctl(rot_data_in);
        rot_error_out   <= rot_err(rot_data_in);
    end

    typedef struct {
        int             cyc;
        bit             id;
        logic [BUS-1:0] frame;
    } txn_t;

    txn_t           inflight[$];
    int             cyc_count = 0;
    bit             m_last    = 1'b1;
    logic [BUS-1:0] exp_rot   = '0;
    bit             exp_valid = 1'b0;
    bit             exp_id    = 1'b0;
    bit             chk_id    = 1'b0;
    logic [BUS-1:0] exp_data  = '0;
    logic [WN-1:0]  exp_ctl   = '0;
    bit             exp_err   = 1'b0;
    int             cnt0      = 0;
    int             cnt1      = 0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: observed %0h expected %0h at t=%0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit rst_n,
                                 input bit v0, input logic [PAY-1:0] p0, input logic [WS-1:0] a0,
                                 input bit v1, input logic [PAY-1:0] p1, input logic [WS-1:0] a1);
        bit   eg0, eg1, gid;
        txn_t t;
        reset        = rst_n;
        req0_valid   = v0;
        req0_payload = p0;
        req0_amount  = a0;
        req1_valid   = v1;
        req1_payload = p1;
        req1_amount  = a1;
        #1;
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (rst_n) begin
            if (v0 && v1) begin
                eg0 = m_last;
                eg1 = !m_last;
            end else begin
                eg0 = v0;
                eg1 = v1;
            end
        end
        checkOutput("req0_ready", 64'(req0_ready), 64'(eg0));
        checkOutput("req1_ready", 64'(req1_ready), 64'(eg1));
        @(posedge clk);
        #1;
        cyc_count++;
        if (!rst_n) begin
            inflight.delete();
            m_last    = 1'b1;
            exp_rot   = '0;
            exp_valid = 1'b0;
            exp_id    = 1'b0;
            chk_id    = 1'b1;
            exp_data  = '0;
            exp_ctl   = '0;
            exp_err   = 1'b0;
            cnt0      = 0;
            cnt1      = 0;
        end else begin
            exp_valid = 1'b0;
            chk_id    = 1'b0;
            if (inflight.size() > 0 && inflight[0].cyc == cyc_count - (LAT + 1)) begin
                t         = inflight.pop_front();
                exp_valid = 1'b1;
                exp_id    = t.id;
                chk_id    = 1'b1;
                exp_data  = rot_scramble(t.frame);
                exp_ctl   = rot_ctl(t.frame);
                exp_err   = rot_err(t.frame);
                if (exp_err) begin
                    if (t.id) cnt1 = (cnt1 == 255) ? 255 : cnt1 + 1;
                    else      cnt0 = (cnt0 == 255) ? 255 : cnt0 + 1;
                end
            end
            if (eg0 || eg1) begin
                gid     = eg1;
                exp_rot = gid ? {4'hF, p1, a1} : {4'hF, p0, a0};
                t.cyc   = cyc_count;
                t.id    = gid;
                t.frame = exp_rot;
                inflight.push_back(t);
                m_last  = gid;
            end else begin
                exp_rot = '0;
            end
        end
        checkOutput("rot_data_in", 64'(rot_data_in), 64'(exp_rot));
        checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
        if (chk_id) checkOutput("rsp_id", 64'(rsp_id), 64'(exp_id));
        checkOutput("rsp_data", 64'(rsp_data), 64'(exp_data));
        checkOutput("rsp_control", 64'(rsp_control), 64'(exp_ctl));
        checkOutput("rsp_error", 64'(rsp_error), 64'(exp_err));
        checkOutput("err_cnt0", 64'(err_cnt0), 64'(cnt0));
        checkOutput("err_cnt1", 64'(err_cnt1), 64'(cnt1));
    endtask

    task automatic idleCycle(input bit rst_n);
        applyStimulus(rst_n, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [PAY-1:0] pa, pb;
        idleCycle(1'b0);
        idleCycle(1'b0);

        // Single request from requester 0 and its response two edges later.
        applyStimulus(1'b1, 1'b1, 24'h123456, 4'd2, 1'b0, '0, '0);
        checkOutput("tp1_frame", 64'(rot_data_in), 64'h0000_0000_F123_4562);
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("tp1_rsp", 64'({rsp_valid, rsp_id}), 64'h2);

        // Continuous contention alternates owners with no idle frames.
        for (int i = 0; i < 4; i++) begin
            pa = PAY'($urandom);
            pb = PAY'($urandom);
            applyStimulus(1'b1, 1'b1, pa, WS'($urandom_range(0, 7)),
                                1'b1, pb, WS'($urandom_range(0, 7)));
        end
        idleCycle(1'b1);
        idleCycle(1'b1);

        // Out-of-range amount from requester 1 produces an owned error.
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 24'hABCDEF, 4'd9);
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("tp3_err", 64'({rsp_valid, rsp_id, rsp_error}), 64'h7);
        checkOutput("tp3_cnt1", 64'(err_cnt1), 64'd1);

        // Saturation of requester 0's counter.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b1, 1'b1, PAY'($urandom), WS'($urandom_range(8, 15)),
                                1'b0, '0, '0);
        end
        idleCycle(1'b1);
        idleCycle(1'b1);
        checkOutput("sat_cnt0", 64'(err_cnt0), 64'd255);

        // Reset right after a grant drops the in-flight frame.
        applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 24'h00FACE, 4'd3);
        idleCycle(1'b0);
        checkOutput("rst_rot_in", 64'(rot_data_in), 64'd0);
        applyStimulus(1'b1, 1'b1, 24'h111111, 4'd1, 1'b1, 24'h222222, 4'd2);
        checkOutput("rst_first_grant", 64'(rot_data_in), 64'h0000_0000_F111_1111);
        idleCycle(1'b1);

        // Quiet period.
        for (int i = 0; i < 5; i++) idleCycle(1'b1);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) != 0),
                          1'($urandom), PAY'($urandom), WS'($urandom_range(0, 15)),
                          1'($urandom), PAY'($urandom), WS'($urandom_range(0, 15)));
        end
        for (int i = 0; i < 3; i++) idleCycle(1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/rotator_scheduler.md
Name: rotator_scheduler

Overview:
- Shares one word-rotator datapath between two requesters.
- Each accepted request becomes a frame {header = all-ones word, payload, amount word} driven onto the rotator input bus.
- Tracks which requester owns each in-flight frame and returns the rotator's data/control/error result to that owner, tagged with its id.
- Keeps a saturating error count per requester.
- Sits between the packet sources and the rotator, replacing direct stimulus drive of the rotator's data_in.

Parameters:
- BUS_SIZE, 32, rotator bus width in bits.
- WORD_SIZE, 4, word width in bits.
- WORD_NUM, BUS_SIZE/WORD_SIZE, words per bus.
- PAY_SIZE, BUS_SIZE-2*WORD_SIZE, payload (middle section) width.
- ROT_LATENCY, 1, rotator input-to-output latency in clock edges (>=1).
- ERR_CNT_W, 8, width of each error counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- req0_valid  in  1  requester 0 has a frame.
- req0_ready  out  1  requester 0 granted this cycle.
- req0_payload  in  PAY_SIZE  payload words, requester 0.
- req0_amount  in  WORD_SIZE  rotation amount / tail word, requester 0.
- req1_valid, req1_ready, req1_payload, req1_amount  as above, for requester 1.
- rot_data_in  out  BUS_SIZE  frame to rotator.
- rot_data_out  in  BUS_SIZE  rotator data result.
- rot_control_out  in  WORD_NUM  rotator control result.
- rot_error_out  in  1  rotator error flag.
- rsp_valid  out  1  response strobe, one cycle.
- rsp_id  out  1  owner of response (0/1).
- rsp_data  out  BUS_SIZE  captured rot_data_out.
- rsp_control  out  WORD_NUM  captured rot_control_out.
- rsp_error  out  1  captured rot_error_out.
- err_cnt0  out  ERR_CNT_W  saturating error count, requester 0.
- err_cnt1  out  ERR_CNT_W  saturating error count, requester 1.

Behaviour:
- Reset (reset==0 at rising edge):
  - All registered outputs go to 0: rot_data_in, rsp_*, err_cnt*.
  - Tag pipeline cleared.
  - Last-grant pointer set to 1, so requester 0 wins first.
  - In-flight results are discarded; no rsp_valid for frames issued before reset.
  - req*_ready forced to 0 while reset==0.
- Arbitration (combinational ready, one grant per cycle):
  - Only one valid: grant it.
  - Both valid: grant the requester not granted last; pointer updates on each transfer.
  - Transfer = valid & ready at a rising edge; payload and amount must be stable while valid.
- Issue (edge E0 of a transfer): rot_data_in <= {ones(WORD_SIZE), payload, amount}.
  - amount is passed unmodified, including values >= WORD_NUM; error detection belongs to the rotator.
- No transfer at an edge: rot_data_in <= 0, an idle frame whose head is not all-ones.
- Throughput: one frame per cycle, back-to-back, no bubbles.
- Tag pipeline: ROT_LATENCY+1 stages of {valid, id}, shifted every cycle.
  - At edge E0+ROT_LATENCY+1: rsp_valid <= 1, rsp_id <= owner, and rsp_data / rsp_control / rsp_error are sampled from rot_*.
  - Other cycles: rsp_valid <= 0; rsp_data / rsp_control / rsp_error hold their last values.
- Error counters: on a response with rsp_error, the owner's counter increments; it saturates at all-ones (no wrap).
- No backpressure on responses; consumers must accept every rsp_valid.
- Simultaneous events: reset dominates everything. A grant and a response in the same cycle are independent.

Decomposition:
- Package rotator_pkg holds:
  - BUS_SIZE, WORD_SIZE, WORD_NUM defaults.
  - HEADER_WORD constant (all-ones).
  - A frame-building function {header, payload, amount}.
  - A tag typedef {valid, id}.
- Sub-module rr_arbiter2: 2-way round-robin with registered last-grant pointer, reset to 1, producing one-hot grant.
- Top level holds issue register, tag pipeline, response capture and counters.

Test Plan:
- After reset, req0_valid=1, payload=0x123456, amount=2 -> req0_ready=1 that cycle; next cycle rot_data_in=0xF1234562; rsp_valid with rsp_id=0 exactly ROT_LATENCY+1 edges after the handshake.
- Both valid continuously for 4 cycles -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; rot_data_in never 0 between frames.
- req1 amount=9 (WORD_NUM=8) and rotator asserts error -> rsp_error=1, rsp_id=1, err_cnt1=1, err_cnt0 unchanged.
- 300 consecutive error responses on requester 0 (ERR_CNT_W=8) -> err_cnt0 stops at 255 and does not wrap.
- Reset asserted one cycle after a grant -> no rsp_valid for that frame; rot_data_in=0; the next post-reset contention grants requester 0.
- No requests for 5 cycles -> rot_data_in=0, rsp_valid=0 throughout, counters unchanged.
